led_drive_gen: RTL
==================

# led_drive_gen

Sequential LED drive generator placed directly upstream of the LED output pad buffer on the CPLD board. It replaces the constant-high pad drive with a registered, mode-selectable signal: off, solid on, PWM-dimmed blink, or triangular "breathe" fade. The output is one registered bit that connects straight to the pad buffer input.

## Interface
- `DIV`, default 12000: prescaler length in clocks. One `tick` is produced every `DIV` clocks (1 kHz at 12 MHz). Legal range is 2..65535.
- `BLINK_HALF`, default 500: blink half-period, counted in ticks. Legal range is 1..1023.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mode_i`  in  2  drive mode: 0 = OFF, 1 = ON, 2 = BLINK, 3 = BREATHE.
- `level_i`  in  8  PWM brightness for BLINK. 0 = dark, 255 = 255/256 duty.
- `led_o`  out  1  registered LED drive to the pad buffer. 1 = lit.
- `tick_o`  out  1  one-clock prescaler strobe, exported for debug.

## Operation
- **Prescaler:** `pre_cnt` counts 0..DIV-1 and wraps to 0.
  - `tick_o` is registered and equals 1 for exactly the clock after `pre_cnt == DIV-1`.
- **PWM counter:** `pwm_cnt` is 8 bits, free-running, and increments every clock, wrapping 255 -> 0.
  - The comparator output is `pwm_on = (pwm_cnt < duty)`, an unsigned 8-bit compare.
- **Mode register:** `mode_q` samples `mode_i` every clock.
  - When `mode_i != mode_q`, the following are re-initialised in that same cycle: `blink_cnt = 0`, `phase = 1`, `ramp = 0`, breathe state = UP.
  - The prescaler and `pwm_cnt` are never re-initialised by a mode change.
- **OFF:** `led_o = 0`.
- **ON:** `led_o = 1` (solid, no PWM).
- **BLINK:** `duty = level_i`; `led_o = phase & pwm_on`.
  - On each tick, `blink_cnt` increments.
  - When `blink_cnt == BLINK_HALF-1` and a tick occurs, `blink_cnt` returns to 0 and `phase` toggles.
- **BREATHE:** a 2-state FSM {UP, DOWN}; `duty = ramp`; `led_o = pwm_on`.
  - UP, on tick: if `ramp == 255`, go to DOWN and `ramp = 254`; else `ramp + 1`.
  - DOWN, on tick: if `ramp == 0`, go to UP and `ramp = 1`; else `ramp - 1`.
  - The endpoints are held for exactly one tick. The full period is 510 ticks.
- **Priority:** a mode change in the same cycle as a tick takes precedence; the tick's effect on the counters is discarded for that cycle.
- **`level_i`** is sampled combinationally each clock. Changes take effect on the next `led_o` update; no glitch filtering is applied.
- **Reset (asynchronous, `rst_n = 0`):**
  - `led_o = 0`, `tick_o = 0`.
  - `pre_cnt = 0`, `pwm_cnt = 0`, `blink_cnt = 0`, `phase = 0`, `ramp = 0`.
  - State = UP, `mode_q = OFF`.
  - Reset is effective mid-blink or mid-ramp. The first clock after release performs the normal mode-change initialisation if `mode_i != OFF`.

## Timing
- **Mode latency:** if `mode_i` changes before edge N, `mode_q` updates at edge N and `led_o` reflects the new mode at edge N+1 (2 clocks).
- **`level_i` latency:** a change is visible on `led_o` at the next edge.
- **PWM frame:** 256 clocks; `led_o` is high for `duty` clocks per frame, starting at `pwm_cnt = 0`.
- **Blink toggle:** `phase` toggles every `DIV*BLINK_HALF` clocks (0.5 s at defaults).
- **Counter widths:**
  - `pre_cnt` is 16 bits.
  - `blink_cnt` is 10 bits.
  - No counter may overflow within its legal parameter range.
- No combinational path from any input to `led_o`.

## Test plan
- **Reset:** assert `rst_n = 0` mid-BLINK with `led_o = 1` -> `led_o = 0` and `tick_o = 0` immediately (asynchronous); after release with `mode_i = 1`, `led_o = 1` exactly 2 clocks later.
- **Prescaler:** `DIV = 4`, `mode_i = 0` -> `tick_o` pulses one clock wide every 4 clocks, first pulse 4 clocks after reset release; `led_o` stays 0 throughout.
- **BLINK:** `DIV = 4`, `BLINK_HALF = 3`, `level_i = 255`, `mode_i = 2`.
  - `led_o` is high 255 of each 256 clocks while `phase = 1`.
  - `phase` toggles every 12 clocks.
  - With `level_i = 0`, `led_o` is never 1.
- **BREATHE:** `DIV = 2`, `mode_i = 3`.
  - `ramp` goes 0 -> 255 in 255 ticks, then 254 … 0, then 1; 510-tick period.
  - The high count of `led_o` per 256-clock frame equals `ramp`.
- **Mode change colliding with tick:** switch BLINK -> BREATHE on the same clock as `tick_o` -> `ramp = 0`, state UP, and `blink_cnt = 0` after that edge; the tick is not applied.
- **PWM boundary:** `level_i = 1` in BLINK with `phase = 1` -> `led_o` is high only while `pwm_cnt = 0`, i.e. 1 clock per 256.

Source files
------------

// File: rtl/led_drive_gen.sv
// led_drive_gen: registered LED pad drive with OFF / ON / PWM-dimmed blink / breathe fade modes.
// A shared prescaler tick paces blink and breathe; a free-running 8-bit PWM counter sets brightness.
module led_drive_gen #(
    parameter int unsigned DIV        = 12000,
    parameter int unsigned BLINK_HALF = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode_i,
    input  logic [7:0] level_i,
    output logic       led_o,
    output logic       tick_o
);

    // state   | meaning
    // ST_UP   | breathe ramp rising toward 255
    // ST_DOWN | breathe ramp falling toward 0
    localparam logic [0:0] ST_UP   = 1'b0;
    localparam logic [0:0] ST_DOWN = 1'b1;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    localparam logic [15:0] PRE_LAST   = 16'(DIV - 1);
    localparam logic [9:0]  BLINK_LAST = 10'(BLINK_HALF - 1);

    logic [15:0] pre_cnt;
    logic        tick_q;
    logic [7:0]  pwm_cnt;
    logic [1:0]  mode_q;
    logic        mode_chg;

    logic [9:0]  blink_cnt;
    logic [9:0]  blink_cnt_d;
    logic        phase;
    logic        phase_d;

    logic [0:0]  state;
    logic [0:0]  state_d;
    logic [7:0]  ramp;
    logic [7:0]  ramp_d;

    logic [7:0]  duty;
    logic        pwm_on;
    logic        led_d;
    logic        led_q;

    assign mode_chg = (mode_i != mode_q);
    assign tick_o   = tick_q;
    assign led_o    = led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= (pre_cnt == PRE_LAST);
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
        end
    end

    // PWM and mode register run regardless of mode; only the tick consumers restart on a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            mode_q  <= MODE_OFF;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            mode_q  <= mode_i;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt;
        phase_d     = phase;
        if (mode_chg) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (tick_q && (mode_q == MODE_BLINK)) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase;
            end else begin
                blink_cnt_d = blink_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        state_d = state;
        ramp_d  = ramp;
        if (mode_chg) begin
            state_d = ST_UP;
            ramp_d  = '0;
        end else if (tick_q && (mode_q == MODE_BREATHE)) begin
            case (state)
                ST_UP: begin
                    if (ramp == 8'hFF) begin
                        state_d = ST_DOWN;
                        ramp_d  = 8'hFE;
                    end else begin
                        ramp_d = ramp + 8'd1;
                    end
                end
                default: begin
                    if (ramp == 8'h00) begin
                        state_d = ST_UP;
                        ramp_d  = 8'h01;
                    end else begin
                        ramp_d = ramp - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            state     <= ST_UP;
            ramp      <= '0;
        end else begin
            blink_cnt <= blink_cnt_d;
            phase     <= phase_d;
            state     <= state_d;
            ramp      <= ramp_d;
        end
    end

    always_comb begin
        duty   = (mode_q == MODE_BLINK) ? level_i : ramp;
        pwm_on = (pwm_cnt < duty);
        led_d  = 1'b0;
        case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = phase & pwm_on;
            default:    led_d = pwm_on;
        endcase
    end

    // Registered so the pad sees no combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

endmodule
